// File: rtl/rem_pkg.sv
// Shared types and sizing helpers for the round-robin remainder arbiter.
package rem_pkg;

  localparam int REM_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int gnt_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/rem_arbiter_if.sv
// Request/response bundle between the calculator front-end ports and the arbiter.
interface rem_arbiter_if #(parameter int NREQ = 4);
  import rem_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*REM_W-1:0] req_num;
  logic [NREQ*REM_W-1:0] req_den;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [REM_W-1:0]      rsp_rem;
  logic                  rsp_divbyzero;

  modport master (
    output req_valid, req_num, req_den, rsp_ready,
    input  req_ready, rsp_valid, rsp_rem, rsp_divbyzero
  );

  modport slave (
    input  req_valid, req_num, req_den, rsp_ready,
    output req_ready, rsp_valid, rsp_rem, rsp_divbyzero
  );

endinterface

// File: rtl/rem.sv
// Combinational sign-magnitude remainder: sign follows the numerator.
module rem
  import rem_pkg::*;
(
  input  logic [REM_W-1:0] numerator,
  input  logic [REM_W-1:0] denominator,
  output logic [REM_W-1:0] remainder,
  output logic             divbyzero
);

  always_comb begin
    remainder = '0;
    divbyzero = 1'b0;
    remainder[2] = numerator[2];
    if (denominator[1:0] == 2'b00) begin
      divbyzero = 1'b1;
    end else begin
      remainder[1:0] = numerator[1:0] % denominator[1:0];
    end
  end

endmodule

// File: rtl/rem_rr_pick.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
module rem_rr_pick #(
  parameter int NREQ  = 4,
  parameter int GNT_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GNT_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_oh,
  output logic [GNT_W-1:0] gnt_idx,
  output logic             any
);

  int              idx;
  logic [NREQ-1:0] rot;

  // Walk from the farthest offset down so the nearest candidate after ptr wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    rot     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      rot = req >> idx;
      if (rot[0]) begin
        gnt_oh  = NREQ'(1) << idx;
        gnt_idx = GNT_W'(idx);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rem_arbiter.sv
// Shares one remainder unit among NREQ requesters, one operation at a time.
//
//   state | meaning
//   IDLE  | arbitrate; accept one request and latch its operands
//   EXEC  | remainder unit evaluates latched operands; result registered
//   RESP  | result offered to the granted requester until it accepts
module rem_arbiter
  import rem_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic         clk,
  input logic         rst,
  rem_arbiter_if.slave bus
);

  localparam int GNT_W = gnt_w(NREQ);

  state_t           state, state_nxt;
  logic [GNT_W-1:0] ptr, gnt, pick_idx;
  logic [NREQ-1:0]  pick_oh, gnt_oh;
  logic             pick_any;
  logic             accept;
  logic [REM_W-1:0] op_num, op_den, rem_out, rsp_rem_q;
  logic             dbz_out, rsp_dbz_q;

  rem_rr_pick #(
    .NREQ  (NREQ),
    .GNT_W (GNT_W)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  rem u_rem (
    .numerator   (op_num),
    .denominator (op_den),
    .remainder   (rem_out),
    .divbyzero   (dbz_out)
  );

  assign gnt_oh = NREQ'(1) << gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshakes are suppressed while rst is high so nothing is consumed by a dropped cycle.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          bus.req_ready = pick_oh;
          if (pick_any) begin
            accept    = 1'b1;
            state_nxt = EXEC;
          end
        end
        EXEC: state_nxt = RESP;
        RESP: begin
          bus.rsp_valid = gnt_oh;
          if ((bus.rsp_ready & gnt_oh) != '0) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= GNT_W'(NREQ - 1);
      gnt       <= '0;
      op_num    <= '0;
      op_den    <= '0;
      rsp_rem_q <= '0;
      rsp_dbz_q <= 1'b0;
    end else begin
      if (accept) begin
        op_num <= bus.req_num[pick_idx*REM_W +: REM_W];
        op_den <= bus.req_den[pick_idx*REM_W +: REM_W];
        gnt    <= pick_idx;
        ptr    <= pick_idx;
      end
      if (state == EXEC) begin
        rsp_rem_q <= rem_out;
        rsp_dbz_q <= dbz_out;
      end
    end
  end

  assign bus.rsp_rem       = rsp_rem_q;
  assign bus.rsp_divbyzero = rsp_dbz_q;

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));

  a_rsp_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.rsp_valid));

  a_no_accept_busy : assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |-> (bus.req_ready == '0));

  // A held-off response must not change under the requester.
  a_rsp_stable : assert property (@(posedge clk) disable iff (rst)
    (state == RESP && (bus.rsp_ready & gnt_oh) == '0)
      |=> ($stable(bus.rsp_rem) && $stable(bus.rsp_divbyzero)));

endmodule

// File: tb/tb_rem_arbiter.sv
// Directed bench for rem_arbiter with a transaction-level reference model.
module tb_rem_arbiter;
  import rem_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int acc_idx[$];
  int acc_cyc[$];

  bit         m_busy  = 1'b0;
  bit         m_fresh = 1'b0;
  int         m_age   = 0;
  int         m_gnt   = 0;
  int         m_ptr   = NREQ - 1;
  logic [2:0] m_num   = '0;
  logic [2:0] m_den   = '0;

  rem_arbiter_if #(.NREQ(NREQ)) bus();

  rem_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // {divbyzero, rem[2:0]} from the arithmetic definition
  function automatic logic [3:0] exp_res(input logic [2:0] n, input logic [2:0] d);
    int a, b;
    a = int'(n[1:0]);
    b = int'(d[1:0]);
    if (b == 0) return {1'b1, n[2], 2'b00};
    return {1'b0, n[2], 2'(a % b)};
  endfunction

  function automatic int mpick(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] er, ev;
    logic [3:0]      res;
    int              g;
    er = '0;
    ev = '0;
    if (!rst) begin
      if (!m_busy) begin
        g = mpick(bus.req_valid, m_ptr);
        if (g >= 0) er = NREQ'(1) << g;
      end else if (m_age >= 1) begin
        ev = NREQ'(1) << m_gnt;
      end
    end
    chk("req_ready", int'(bus.req_ready), int'(er));
    chk("rsp_valid", int'(bus.rsp_valid), int'(ev));
    if (ev != '0) begin
      res = exp_res(m_num, m_den);
      chk("rsp_rem", int'(bus.rsp_rem), int'(res[2:0]));
      chk("rsp_divbyzero", int'(bus.rsp_divbyzero), int'(res[3]));
    end
    if (!rst && m_fresh) begin
      chk("reset_rsp_rem", int'(bus.rsp_rem), 0);
      chk("reset_rsp_divbyzero", int'(bus.rsp_divbyzero), 0);
    end
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc_idx.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
    end
    m_fresh = 1'b0;
    if (rst) begin
      m_busy  = 1'b0;
      m_ptr   = NREQ - 1;
      m_fresh = 1'b1;
    end else if (!m_busy) begin
      g = mpick(bus.req_valid, m_ptr);
      if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_gnt  = g;
        m_ptr  = g;
        m_num  = bus.req_num[g*3 +: 3];
        m_den  = bus.req_den[g*3 +: 3];
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (bus.rsp_ready[m_gnt]) begin
      m_busy = 1'b0;
    end
  end

  // Called right after a rising edge; returns right after a rising edge.
  task automatic do_op(input int idx, input logic [2:0] n, input logic [2:0] d,
                       output logic [2:0] r, output logic z, output int lat,
                       output logic [NREQ-1:0] rdy);
    bit got;
    int ca;
    r   = '0;
    z   = 1'b0;
    lat = -1;
    rdy = '0;
    ca  = 0;
    bus.req_num[idx*3 +: 3] = n;
    bus.req_den[idx*3 +: 3] = d;
    bus.req_valid[idx]      = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        got = 1'b1;
        ca  = cyc;
        rdy = bus.req_ready;
        break;
      end
    end
    chk("accept_seen", int'(got), 1);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    bus.rsp_ready[idx] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[idx]) begin
        got = 1'b1;
        lat = cyc - ca;
        r   = bus.rsp_rem;
        z   = bus.rsp_divbyzero;
        break;
      end
    end
    chk("response_seen", int'(got), 1);
    @(posedge clk); #1;
    bus.rsp_ready[idx] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0]      r;
    logic            z;
    int              lat, bad, got;
    logic [NREQ-1:0] rdy;
    logic [3:0]      res;
    int              exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    bus.req_valid = '1;
    bus.req_num   = '0;
    bus.req_den   = '0;
    bus.rsp_ready = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("post_rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("post_rst_rsp_rem", int'(bus.rsp_rem), 0);
    @(posedge clk); #1;

    // single op from requester 0
    do_op(0, 3'b011, 3'b010, r, z, lat, rdy);
    chk("t1_req_ready", int'(rdy), 4'b0001);
    chk("t1_latency", lat, 2);
    chk("t1_rem", int'(r), 3'b001);
    chk("t1_dbz", int'(z), 0);

    // all requesters valid, rsp_ready tied high
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_idx.delete();
    acc_cyc.delete();
    bus.req_num   = {3'b111, 3'b110, 3'b101, 3'b011};
    bus.req_den   = {3'b010, 3'b011, 3'b001, 3'b110};
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (acc_idx.size() >= 5) break;
    end
    bus.req_valid = '0;
    chk("t2_accept_count", (acc_idx.size() >= 5) ? 1 : 0, 1);
    if (acc_idx.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t2_grant_order", acc_idx[i], exp_order[i]);
      for (int i = 1; i < 5; i++) chk("t2_accept_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end
    repeat (4) @(posedge clk);
    #1;
    bus.rsp_ready = '0;

    // divide by zero, den sign bit ignored
    do_op(1, 3'b110, 3'b100, r, z, lat, rdy);
    chk("t3a_rem", int'(r), 3'b100);
    chk("t3a_dbz", int'(z), 1);
    do_op(3, 3'b011, 3'b000, r, z, lat, rdy);
    chk("t3b_rem", int'(r), 3'b000);
    chk("t3b_dbz", int'(z), 1);

    // exhaustive operand sweep through requester 2
    for (int n = 0; n < 8; n++) begin
      for (int d = 0; d < 8; d++) begin
        do_op(2, 3'(n), 3'(d), r, z, lat, rdy);
        res = exp_res(3'(n), 3'(d));
        chk("sweep_rem", int'(r), int'(res[2:0]));
        chk("sweep_dbz", int'(z), int'(res[3]));
        if (n == 5 && d == 3) chk("sweep_pin_5_3", int'(r), 3'b101);
        if (n == 7 && d == 6) chk("sweep_pin_7_6", int'(r), 3'b101);
      end
    end

    // response back-pressure with requester 1 still requesting
    bus.req_num[3 +: 3] = 3'b111;
    bus.req_den[3 +: 3] = 3'b010;
    bus.req_valid[1]    = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready[1]) begin got = 1; break; end
    end
    chk("t5_first_accept", got, 1);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[1]) begin got = 1; break; end
    end
    chk("t5_rsp_seen", got, 1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("t5_hold_rsp_valid", int'(bus.rsp_valid), 4'b0010);
      chk("t5_hold_rsp_rem", int'(bus.rsp_rem), 3'b101);
      chk("t5_hold_req_ready", int'(bus.req_ready), 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("t5_release_rsp_valid", int'(bus.rsp_valid), 4'b0010);
    @(posedge clk); #1;
    bus.rsp_ready[1] = 1'b0;
    @(negedge clk);
    chk("t5_reaccept", int'(bus.req_ready), 4'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    bus.rsp_ready[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.rsp_ready = '0;

    // reset during EXEC drops the operation
    bus.req_num[9 +: 3] = 3'b011;
    bus.req_den[9 +: 3] = 3'b010;
    bus.req_valid[3]    = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready[3]) begin got = 1; break; end
    end
    chk("t6_accept", got, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    @(negedge clk);
    chk("t6_exec_rsp_valid", int'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", int'(bus.rsp_valid), 0);
    chk("t6_req_ready", int'(bus.req_ready), 0);
    chk("t6_rsp_rem", int'(bus.rsp_rem), 0);
    chk("t6_dbz", int'(bus.rsp_divbyzero), 0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) bad++;
    end
    chk("t6_no_stale_rsp", bad, 0);
    @(posedge clk); #1;
    bus.req_valid = '1;
    @(negedge clk);
    chk("t6_first_grant", int'(bus.req_ready), 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    bus.rsp_ready = '0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rem_arbiter.md
# rem_arbiter

Round-robin scheduler sharing one combinational `rem` unit (3-bit sign-magnitude remainder: bit 2 sign, bits [1:0] magnitude, `divbyzero` flag) among NREQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block latches operands, sequences one operation through `rem`, registers the result, and returns it to the granted requester. It sits between the calculator front-end ports and the single shared remainder datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  one-hot grant; handshake on req_valid[i] & req_ready[i]
- req_num  in  NREQ*3  packed numerators, requester i at [3i+2:3i]
- req_den  in  NREQ*3  packed denominators, same packing
- rsp_valid  out  NREQ  one-hot; response for requester i on shared bus
- rsp_ready  in  NREQ  requester i accepts response
- rsp_rem  out  3  remainder, meaningful while any rsp_valid bit is high
- rsp_divbyzero  out  1  divide-by-zero flag, qualified like rsp_rem

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: pick winner g = first i with req_valid[i], searching from ptr+1 upward, wrapping modulo NREQ. req_ready = onehot(g) combinationally; all zero if no req_valid. On handshake: latch num/den of g into op registers, latch g into gnt, ptr <= g, go EXEC.
- EXEC: drive `rem` from op registers; register outputs into rsp registers; go RESP.
- RESP: rsp_valid = onehot(gnt). On rsp_ready[gnt]: go IDLE. rsp_ready of other indices ignored.
- Result rules: den[1:0] != 0 -> rsp_rem[1:0] = num[1:0] % den[1:0], rsp_divbyzero = 0. den[1:0] == 0 (den = 000 or 100) -> rsp_divbyzero = 1, rsp_rem[1:0] = 00. In all cases rsp_rem[2] = num[2] (sign follows dividend; den[2] ignored).
- req_ready never asserted outside IDLE; no new accept while a response is outstanding.
- A requester may drop req_valid before being granted; arbitration is re-evaluated every IDLE cycle.
- Fairness: a requester holding req_valid is granted within NREQ accepts.

## Timing
- Reset: state IDLE, ptr = NREQ-1 (requester 0 wins first), gnt = 0, req_ready = 0 while rst high, rsp_valid = 0, rsp_rem = 000, rsp_divbyzero = 0.
- Accept at edge T (end of IDLE cycle) -> EXEC cycle T+1 -> rsp_valid high from cycle T+2.
- Response handshake at edge U -> IDLE in cycle U+1; next accept possible at edge U+1. Minimum 3 cycles per operation.
- rsp_ready held low: stays in RESP indefinitely, rsp_rem/rsp_divbyzero stable, all req_ready low.
- rsp_ready already high on first RESP cycle: single-cycle response.
- Simultaneous req_valid from all: grants in order ptr+1, ptr+2, ... wrapping NREQ-1 -> 0.
- rst asserted in any state: next cycle IDLE with reset values; in-flight operation dropped, no response issued.

## Structure
- Package `rem_pkg`: REM_W = 3, state typedef (IDLE/EXEC/RESP), GNT_W = $clog2(NREQ) helper.
- Instantiates existing `rem` unchanged (numerator, denominator, remainder, divbyzero).
- One sub-module `rem_rr_pick`: combinational round-robin priority picker (req vector, ptr -> one-hot grant, index, any).

## Test plan
- Reset, then req_valid = 0001, num 011, den 010 -> req_ready = 0001 same cycle, rsp_valid = 0001 two cycles later, rsp_rem = 001, rsp_divbyzero = 0.
- All four requesters valid continuously with rsp_ready tied high -> grant order 0,1,2,3,0, one accept every 3 cycles.
- num 110, den 100 -> rsp_divbyzero = 1, rsp_rem = 100; num 011, den 000 -> rsp_divbyzero = 1, rsp_rem = 000.
- Exhaustive sweep num 000..111, den 000..111 via requester 2 -> rsp_rem[1:0] = num[1:0] % den[1:0] when den[1:0] != 0, rsp_rem[2] = num[2] always.
- Hold rsp_ready low 10 cycles with requester 1 valid -> rsp_valid and rsp_rem stable, req_ready = 0 throughout; release -> requester 1 accepted the cycle after.
- Assert rst in EXEC cycle -> no rsp_valid ever for that op; all outputs at reset values next cycle; next grant goes to requester 0.
